spi_mem_host: RTL
=================

# spi_mem_host

Bit-serial initiator for the team's SPI memory responder. It accepts single-byte read/write requests on a parallel host port and serialises each into the responder's frame: chip-select, mode bit, LSB-first address/data. For reads it collects the returned byte, and it completes every transaction on the responder's `op_done`. It sits between the testbench or host logic and the memory responder, on the same `clk`.

## Interface

**Parameters**
- `TIMEOUT_CYCLES`, 64: maximum cycles spent waiting for `ready` or `op_done` before aborting.

**Ports**
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req` in 1: transaction request, sampled only when `busy`=0.
- `we` in 1: 1 = write, 0 = read; captured with `req`.
- `addr` in 8: memory address; captured with `req`.
- `wdata` in 8: write byte; captured with `req`.
- `busy` out 1: high from the accept edge until the `done` pulse.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 8: read byte; updated at read completion, held otherwise.
- `err` out 1: valid with `done`; 1 = timeout abort.
- `cs` out 1: chip select to responder, active-low.
- `miso` out 1: serial command/data to responder.
- `mosi` in 1: serial read data from responder.
- `ready` in 1: responder read-data-valid flag.
- `op_done` in 1: responder completion flag.

## Operation

- **Reset values:** `cs`=1, `miso`=0, `busy`=0, `done`=0, `err`=0, `rdata`=0; state IDLE.
- **Outputs:** all registered.
- **IDLE:** `cs`=1, `miso`=0. On `req`=1, the edge is "edge 0".
  - Latch `we`, `addr`, `wdata` into a 16-bit shift register, `{wdata, addr}`.
  - Drive `cs`=0, `miso`=`we`, `busy`=1.
  - Go to MODE.
- **MODE:** hold `cs`=0 and `miso`=`we` for one more cycle, so the mode bit is presented for two cycles. Go to SHIFT.
- **SHIFT:** drive one bit per cycle, LSB first, `cs`=0.
  - Write: 16 bits, `addr[0..7]` then `wdata[0..7]`.
  - Read: 8 bits, `addr[0..7]`.
  - After the last bit, drive `cs`=1 and `miso`=0, then go to WAIT_DONE (write) or WAIT_RDY (read).
- **WAIT_RDY:**
  - On the first edge sampling `ready`=1, capture `mosi` as bit 0 and go to RECV, with bit counter = 1.
- **RECV:**
  - Capture `mosi` into bit[counter] on each edge.
  - After bit 7, go to WAIT_DONE.
  - `ready` is not re-checked.
- **WAIT_DONE:**
  - On sampling `op_done`=1, pulse `done`=1 and drop `busy`=0.
  - On a read, load `rdata` with the assembled byte on the same edge.
  - Return to IDLE.
- **Timeout:**
  - A counter clears on entry to WAIT_RDY or WAIT_DONE and increments each cycle in those states.
  - On reaching `TIMEOUT_CYCLES`: pulse `done`=1 with `err`=1, leave `rdata` unchanged, return to IDLE.
  - `cs` is already 1 at this point.
- **Request handling:** `req` while `busy`=1 is ignored, not queued. `req` on the same edge as a `done` pulse is ignored; it is accepted on the next cycle at the earliest.
- **Ignored inputs:** `mosi` outside WAIT_RDY/RECV; `ready` and `op_done` in IDLE/MODE/SHIFT.
- **Reset mid-transaction:** the next edge returns to reset values and `cs`=1 without a `done` pulse. The responder must share the same reset.

## Timing

Edge numbers are relative to the accept edge (0).

- **Chip select:** `cs`=0 after edges 0..17 for a write, 0..9 for a read. `cs`=1 after edge 18 (write) or edge 10 (read).
- **Serial bits:** `miso` = mode after edges 0 and 1. Bit j follows edge 2+j.
- **Write:** the responder's `op_done` is sampled at edge 20; `done` is high after edge 20. Latency is 21 cycles from accept to `done`.
- **Read:**
  - `ready` is first sampled high at edge 13, capturing bit 0.
  - Bits 0..7 are captured at edges 13..20.
  - `op_done` is sampled at edge 21; `done` and `rdata` are valid after edge 21.
  - Latency is 22 cycles.
- **Back-to-back:** with `req` held high, the next transaction is accepted one cycle after `done`. This gives a minimum IDLE dwell of 1 cycle, so the responder always sees `cs`=1 in its idle state.

## Test plan

- **Reset:** assert `rst` for 3 cycles → `cs`=1, `miso`=0, `busy`=0, `done`=0, `rdata`=0x00, `err`=0.
- **Write:** `addr`=0x05, `wdata`=0xA5, `we`=1 → `miso` sequence 1,1, then 1,0,1,0,0,0,0,0, then 1,0,1,0,0,1,0,1; `cs` low for 18 cycles; `done` after edge 20 with `err`=0.
- **Readback:** read `addr`=0x05 after the write → `done` after edge 21, `rdata`=0xA5, `err`=0; `cs` low for exactly 10 cycles.
- **Back-to-back:**
  - Write 0x3C to addr 0x1F, with `req` held high, then read addr 0x1F → second accept exactly 1 cycle after the first `done`, `rdata`=0x3C.
  - Read an unwritten addr 0x00 → `rdata`=0x00.
- **Timeout:** responder held in reset, read of addr 0x02 with `TIMEOUT_CYCLES`=64 → `done`=1 and `err`=1 exactly 64 cycles after entering WAIT_RDY, `rdata` unchanged, `cs`=1.
- **Reset mid-frame:** assert `rst` at edge 6 of a write → `cs`=1 and `busy`=0 next cycle, no `done`. A subsequent write/read of addr 0x07 with 0x81 returns 0x81.

Source files
------------

// File: rtl/spi_mem_host_if.sv
// spi_mem_host_if: host request port plus serial link to the responder.
// master = host/responder side, slave = spi_mem_host.
interface spi_mem_host_if;
  logic       req;
  logic       we;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       err;
  logic       cs;
  logic       miso;
  logic       mosi;
  logic       ready;
  logic       op_done;

  modport master (
    output req, we, addr, wdata,
    output mosi, ready, op_done,
    input  busy, done, rdata, err,
    input  cs, miso
  );

  modport slave (
    input  req, we, addr, wdata,
    input  mosi, ready, op_done,
    output busy, done, rdata, err,
    output cs, miso
  );
endinterface

// File: rtl/spi_mem_host.sv
// spi_mem_host: bit-serial initiator for the SPI memory responder.
// Frames single-byte reads/writes, LSB first, with a wait timeout.
module spi_mem_host #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic           clk,
  input logic           rst,
  spi_mem_host_if.slave bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] MODE      = 3'd1;
  localparam logic [2:0] SHIFT     = 3'd2;
  localparam logic [2:0] WAIT_RDY  = 3'd3;
  localparam logic [2:0] RECV      = 3'd4;
  localparam logic [2:0] WAIT_DONE = 3'd5;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]    state;
  logic          we_q;
  logic [15:0]   sr;
  logic [4:0]    cnt;
  logic [7:0]    rbuf;
  logic [TW-1:0] tmr;
  logic          cs_q;
  logic          miso_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic [7:0]    rdata_q;
  logic [4:0]    nbits;
  logic          tmo;

  assign bus.cs    = cs_q;
  assign bus.miso  = miso_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

  assign nbits = we_q ? 5'd16 : 5'd8;
  assign tmo   = (tmr == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      sr      <= '0;
      cnt     <= '0;
      rbuf    <= '0;
      tmr     <= '0;
      cs_q    <= 1'b1;
      miso_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            we_q   <= bus.we;
            sr     <= {bus.wdata, bus.addr};
            cs_q   <= 1'b0;
            miso_q <= bus.we;
            busy_q <= 1'b1;
            state  <= MODE;
          end
        end
        // mode bit stays on the line a second cycle
        MODE: begin
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          if (cnt == nbits) begin
            cs_q   <= 1'b1;
            miso_q <= 1'b0;
            tmr    <= '0;
            state  <= we_q ? WAIT_DONE : WAIT_RDY;
          end else begin
            miso_q <= sr[0];
            sr     <= {1'b0, sr[15:1]};
            cnt    <= cnt + 5'd1;
          end
        end
        WAIT_RDY: begin
          if (bus.ready) begin
            rbuf[0] <= bus.mosi;
            cnt     <= 5'd1;
            state   <= RECV;
          end else if (tmo) begin
            done_q <= 1'b1;
            err_q  <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        RECV: begin
          rbuf[cnt[2:0]] <= bus.mosi;
          if (cnt == 5'd7) begin
            tmr   <= '0;
            state <= WAIT_DONE;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        WAIT_DONE: begin
          if (bus.op_done) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            if (!we_q) rdata_q <= rbuf;
            state <= IDLE;
          end else if (tmo) begin
            done_q <= 1'b1;
            err_q  <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
